// File: rtl/mul_arbiter.sv
// Round-robin arbiter that shares one pipelined fixed-point multiplier among N_REQ
// requesters, returning each product tagged with the requester ID, with a hang watchdog.
module mul_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 16,
  parameter int ID_W        = $clog2(N_REQ)
) (
  input  logic                    I_CLK,
  input  logic                    I_RST_N,
  input  logic [N_REQ-1:0]        I_REQ_VLD,
  input  logic [N_REQ*DATA_W-1:0] I_REQ_M1,
  input  logic [N_REQ*DATA_W-1:0] I_REQ_M2,
  output logic [N_REQ-1:0]        O_REQ_ACK,
  output logic [N_REQ-1:0]        O_RSP_VLD,
  output logic [DATA_W-1:0]       O_RSP_PRODUCT,
  output logic                    O_RSP_ERR,
  output logic [ID_W-1:0]         O_RSP_ID,
  output logic                    O_MUL_VLD,
  output logic [DATA_W-1:0]       O_MUL_M1,
  output logic [DATA_W-1:0]       O_MUL_M2,
  input  logic                    I_MUL_BUSY,
  input  logic                    I_MUL_VLD,
  input  logic [DATA_W-1:0]       I_MUL_PRODUCT,
  input  logic                    I_CLR_ERR,
  output logic                    O_BUSY,
  output logic                    O_TIMEOUT
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timed_out;

  logic               grant_vld;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    cand;
  logic               can_grant;

  logic [N_REQ-1:0]   req_ack_q, req_ack_d;
  logic [N_REQ-1:0]   rsp_vld_q, rsp_vld_d;
  logic [DATA_W-1:0]  rsp_product_q, rsp_product_d;
  logic               rsp_err_q, rsp_err_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic               mul_vld_q, mul_vld_d;
  logic [DATA_W-1:0]  mul_m1_q, mul_m1_d;
  logic [DATA_W-1:0]  mul_m2_q, mul_m2_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;

  logic [DATA_W-1:0]  m1_arr [N_REQ];
  logic [DATA_W-1:0]  m2_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign m1_arr[g] = I_REQ_M1[g*DATA_W +: DATA_W];
    assign m2_arr[g] = I_REQ_M2[g*DATA_W +: DATA_W];
  end

  // Scan from farthest to nearest after ptr so the nearest requester is the last writer.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(ptr_q) + k) % N_REQ);
      if (I_REQ_VLD[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign can_grant = grant_vld && !I_MUL_BUSY;

  // State and output registers
  always_ff @(posedge I_CLK) begin
    // NOTE: reset is synchronous, sampled only on the clock edge like any other input.
    if (!I_RST_N) begin
      state_q       <= S_IDLE;
      ptr_q         <= ID_W'(N_REQ - 1);
      id_q          <= '0;
      cnt_q         <= '0;
      req_ack_q     <= '0;
      rsp_vld_q     <= '0;
      rsp_product_q <= '0;
      rsp_err_q     <= 1'b0;
      rsp_id_q      <= '0;
      mul_vld_q     <= 1'b0;
      mul_m1_q      <= '0;
      mul_m2_q      <= '0;
      busy_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      id_q          <= id_d;
      cnt_q         <= cnt_d;
      req_ack_q     <= req_ack_d;
      rsp_vld_q     <= rsp_vld_d;
      rsp_product_q <= rsp_product_d;
      rsp_err_q     <= rsp_err_d;
      rsp_id_q      <= rsp_id_d;
      mul_vld_q     <= mul_vld_d;
      mul_m1_q      <= mul_m1_d;
      mul_m2_q      <= mul_m2_d;
      busy_q        <= busy_d;
      timeout_q     <= timeout_d;
    end
  end

  // Next-state logic. RESP also arbitrates, so a new grant can overlap the response
  // cycle and the multiplier is reloaded as soon as it drops busy.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    timed_out = 1'b0;
    unique case (state_q)
      S_IDLE, S_RESP: begin
        if (can_grant) begin
          state_d = S_ISSUE;
          ptr_d   = grant_idx;
          id_d    = grant_idx;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (I_MUL_VLD) begin
          state_d = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d   = S_RESP;
          timed_out = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    req_ack_d     = '0;
    rsp_vld_d     = '0;
    rsp_product_d = rsp_product_q;
    rsp_err_d     = rsp_err_q;
    rsp_id_d      = rsp_id_q;
    mul_vld_d     = 1'b0;
    mul_m1_d      = mul_m1_q;
    mul_m2_d      = mul_m2_q;
    busy_d        = (state_d != S_IDLE);
    timeout_d     = timeout_q;

    if (state_d == S_ISSUE) begin
      mul_vld_d = 1'b1;
      req_ack_d = N_REQ'(1) << grant_idx;
      mul_m1_d  = m1_arr[grant_idx];
      mul_m2_d  = m2_arr[grant_idx];
    end

    if (state_d == S_RESP) begin
      rsp_vld_d     = N_REQ'(1) << id_q;
      rsp_id_d      = id_q;
      rsp_err_d     = timed_out;
      rsp_product_d = timed_out ? '0 : I_MUL_PRODUCT;
    end

    // A timeout in the same cycle as a clear request keeps the flag set.
    if (timed_out) begin
      timeout_d = 1'b1;
    end else if (I_CLR_ERR) begin
      timeout_d = 1'b0;
    end
  end

  assign O_REQ_ACK     = req_ack_q;
  assign O_RSP_VLD     = rsp_vld_q;
  assign O_RSP_PRODUCT = rsp_product_q;
  assign O_RSP_ERR     = rsp_err_q;
  assign O_RSP_ID      = rsp_id_q;
  assign O_MUL_VLD     = mul_vld_q;
  assign O_MUL_M1      = mul_m1_q;
  assign O_MUL_M2      = mul_m2_q;
  assign O_BUSY        = busy_q;
  assign O_TIMEOUT     = timeout_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a behavioural multiplier_16 stand-in
// (busy for 4 cycles after I_VLD, O_VLD on the last busy cycle, Q2.13 signed product).
module tb_mul_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]   req_vld;
  logic [N*W-1:0] req_m1, req_m2;
  logic [N-1:0]   req_ack, rsp_vld;
  logic [W-1:0]   rsp_product;
  logic           rsp_err;
  logic [1:0]     rsp_id;
  logic           mul_vld;
  logic [W-1:0]   mul_m1, mul_m2;
  logic           mul_busy, mul_o_vld;
  logic [W-1:0]   mul_product;
  logic           clr_err, busy, timeout;

  logic force_busy, hang, spur_vld;

  mul_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT_CYC(TO)) dut (
    .I_CLK         (clk),
    .I_RST_N       (rst_n),
    .I_REQ_VLD     (req_vld),
    .I_REQ_M1      (req_m1),
    .I_REQ_M2      (req_m2),
    .O_REQ_ACK     (req_ack),
    .O_RSP_VLD     (rsp_vld),
    .O_RSP_PRODUCT (rsp_product),
    .O_RSP_ERR     (rsp_err),
    .O_RSP_ID      (rsp_id),
    .O_MUL_VLD     (mul_vld),
    .O_MUL_M1      (mul_m1),
    .O_MUL_M2      (mul_m2),
    .I_MUL_BUSY    (mul_busy),
    .I_MUL_VLD     (mul_o_vld),
    .I_MUL_PRODUCT (mul_product),
    .I_CLR_ERR     (clr_err),
    .O_BUSY        (busy),
    .O_TIMEOUT     (timeout)
  );

  // Multiplier stand-in
  logic              stub_busy_q, stub_vld_q;
  logic [1:0]        stub_cnt_q;
  logic [W-1:0]      stub_prod_q;
  logic signed [2*W-1:0] full;

  assign full = $signed(mul_m1) * $signed(mul_m2);

  always @(posedge clk) begin
    if (!rst_n) begin
      stub_busy_q <= 1'b0;
      stub_vld_q  <= 1'b0;
      stub_cnt_q  <= '0;
      stub_prod_q <= '0;
    end else begin
      stub_vld_q <= 1'b0;
      if (!stub_busy_q) begin
        if (mul_vld) begin
          stub_busy_q <= 1'b1;
          stub_cnt_q  <= '0;
          stub_prod_q <= full[W+12:13];
        end
      end else if (stub_cnt_q == 2'd2) begin
        stub_vld_q <= !hang;
        stub_cnt_q <= 2'd3;
      end else if (stub_cnt_q == 2'd3) begin
        stub_busy_q <= 1'b0;
      end else begin
        stub_cnt_q <= stub_cnt_q + 2'd1;
      end
    end
  end

  assign mul_busy    = stub_busy_q | force_busy;
  assign mul_o_vld   = stub_vld_q | spur_vld;
  assign mul_product = stub_prod_q;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack_rsp"}, {req_ack, rsp_vld}, 32'h0);
    check({tag, "_rsp_data"}, {rsp_product, rsp_err, rsp_id}, 32'h0);
    check({tag, "_mul_ops"}, {mul_m1, mul_m2}, 32'h0);
    check({tag, "_ctl"}, {mul_vld, busy, timeout}, 32'h0);
  endtask

  // Single request from requester id; ack expected next cycle, response 6 cycles after grant.
  task automatic do_txn(input int id, input logic [W-1:0] m1, input logic [W-1:0] m2,
                        input logic [W-1:0] prod, input string tag);
    logic [N-1:0] oh;
    oh      = N'(1) << id;
    req_vld = oh;
    req_m1  = '0;
    req_m2  = '0;
    req_m1[id*W +: W] = m1;
    req_m2[id*W +: W] = m2;
    tick();
    check({tag, "_ack"}, req_ack, oh);
    check({tag, "_mul_vld"}, mul_vld, 1);
    check({tag, "_ops"}, {mul_m1, mul_m2}, {m1, m2});
    req_vld = '0;
    tick(4);
    check({tag, "_early"}, rsp_vld, 0);
    tick();
    check({tag, "_rsp_vld"}, rsp_vld, oh);
    check({tag, "_rsp"}, {rsp_err, rsp_id, rsp_product}, {1'b0, 2'(id), prod});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n_ack, n_rsp, last_ack, last_rsp, cyc, exp_id;
    rst_n = 1'b0; req_vld = '0; req_m1 = '0; req_m2 = '0;
    clr_err = 1'b0; force_busy = 1'b0; hang = 1'b0; spur_vld = 1'b0;
    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // A multiplier VLD outside WAIT must not produce a response.
    spur_vld = 1'b1;
    tick();
    spur_vld = 1'b0;
    check("spur_rsp", {rsp_vld, busy}, 0);
    tick();
    check("spur_rsp2", {rsp_vld, busy}, 0);

    do_txn(0, 16'h2000, 16'h4000, 16'h4000, "single");
    do_txn(2, 16'hE000, 16'h2000, 16'hE000, "signed");

    // Fairness from a fresh reset: all requesters held high.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_m1[i*W +: W] = 16'h2000;
      req_m2[i*W +: W] = W'(16'h0100 * (i + 1));
    end
    req_vld = '1;
    n_ack = 0; n_rsp = 0; last_ack = -1; last_rsp = -1; cyc = 0;
    while (n_rsp < 20 && cyc < 300) begin
      tick();
      cyc++;
      if (req_ack != '0) begin
        check("fair_ack", req_ack, N'(1) << (n_ack % N));
        if (last_ack >= 0) check("fair_ack_gap", cyc - last_ack, 6);
        last_ack = cyc;
        n_ack++;
        if (n_ack == 20) req_vld = '0;
      end
      if (rsp_vld != '0) begin
        exp_id = n_rsp % N;
        check("fair_rsp", {rsp_err, rsp_id, rsp_vld, rsp_product},
              {1'b0, 2'(exp_id), N'(1) << exp_id, W'(16'h0100 * (exp_id + 1))});
        if (last_rsp >= 0) check("fair_rsp_gap", cyc - last_rsp, 6);
        last_rsp = cyc;
        n_rsp++;
      end
    end
    check("fair_count", n_rsp, 20);

    // Busy interlock: request pending while the multiplier reports busy.
    force_busy = 1'b1;
    req_vld    = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("intlk_hold", {req_ack, mul_vld}, 0);
    end
    force_busy = 1'b0;
    do_txn(1, 16'h2000, 16'h1000, 16'h1000, "intlk");

    // Timeout: multiplier never returns VLD; clear in the timeout cycle loses.
    hang    = 1'b1;
    req_vld = 4'b0100;
    req_m1[2*W +: W] = 16'h2000;
    req_m2[2*W +: W] = 16'h2000;
    tick();
    check("to_ack", req_ack, 4'b0100);
    req_vld = '0;
    tick(16);
    check("to_early", {rsp_vld, timeout}, 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("to_rsp_vld", rsp_vld, 4'b0100);
    check("to_rsp", {rsp_err, rsp_id, rsp_product}, {1'b1, 2'd2, 16'h0000});
    check("to_set_wins", timeout, 1);
    tick(3);
    check("to_sticky", timeout, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("to_cleared", timeout, 0);
    hang = 1'b0;
    tick(2);

    // Reset in the middle of WAIT abandons the transaction.
    req_vld = 4'b0010;
    tick();
    check("mid_ack", req_ack, 4'b0010);
    req_vld = '0;
    tick(2);
    rst_n = 1'b0;
    tick();
    check_all_zero("midrst");
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("midrst_quiet", rsp_vld, 0);
    end
    req_m1[0 +: W] = 16'h2000;
    req_m2[0 +: W] = 16'h2000;
    req_vld = '1;
    tick();
    check("post_rst_ack", req_ack, 4'b0001);
    req_vld = '0;
    tick(5);
    check("post_rst_rsp", {rsp_vld, rsp_err, rsp_id, rsp_product}, {4'b0001, 1'b0, 2'd0, 16'h2000});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
